ppa_mw_sequencer: RTL

Multi-word adder sequencer built around the existing 16-bit `PPA` parallel-prefix adder. It accepts two WORDS×16-bit operands plus carry-in over a valid/ready handshake. It feeds the `PPA` one 16-bit slice per cycle, least-significant first, registering each slice's `Cout` back into the next slice's `Cin`. It then presents the full-width sum and final carry-out on a valid/ready output port. The block is the operand-feeding and carry-chaining stage directly upstream and downstream of the `PPA` instance, giving wide additions without widening the adder.

---
 rtl/ppa_mw_sequencer_if.sv | 26 ++
 rtl/ppa_mw_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ppa_mw_sequencer_if.sv
// Operand/result handshake bundle for the multi-word adder sequencer.
// The slave view belongs to the sequencer; the master view belongs to
// whoever produces operands and consumes results.
interface ppa_mw_sequencer_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   a;
    logic [16*WORDS-1:0]   b;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   sum;
    logic                  cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/ppa_mw_sequencer.sv
// Multi-word adder sequencer: a single 16-bit parallel-prefix adder (PPA)
// is reused once per 16-bit slice, least-significant slice first, with the
// slice carry-out registered and fed back as the next slice's carry-in.

// 16-bit Kogge-Stone parallel-prefix adder with carry-in.
module PPA (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;

    // Four prefix levels (span 1, 2, 4, 8) build group generate/propagate,
    // then carry-in is folded in to form every bit's carry.
    always_comb begin
        g = A & B;
        p = A ^ B;
        for (int l = 0; l < 4; l++) begin
            g = g | (p & (g << (1 << l)));
            p = p & ((p << (1 << l)) | ((16'd1 << (1 << l)) - 16'd1));
        end
        c    = {g | (p & {16{Cin}}), Cin};
        S    = (A ^ B) ^ c[15:0];
        Cout = c[16];
    end
endmodule

// Sequencer top: captures wide operands, walks the slices, holds the result.
module ppa_mw_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ppa_mw_sequencer_if.slave        bus
);
    localparam int N  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [N-1:0]    sum_reg;
    logic            carry_reg;
    logic [IW-1:0]   idx;
    logic [15:0]     slice_s;
    logic            slice_cout;
    logic            last_slice;
    logic            accept;

    assign last_slice = (idx == IW'(WORDS - 1));
    assign accept     = bus.in_valid && (state_q == IDLE);

    // Handshake flags come from the state register alone, so neither
    // in_valid nor out_ready has a combinational path to an output.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = carry_reg;

    PPA u_ppa (
        .A    (a_reg[16*idx +: 16]),
        .B    (b_reg[16*idx +: 16]),
        .Cin  (carry_reg),
        .S    (slice_s),
        .Cout (slice_cout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept, walk every slice, then wait for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)        state_d = RUN;
            RUN:  if (last_slice)    state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice accumulation of sum and carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[16*idx +: 16] <= slice_s;
                    carry_reg             <= slice_cout;
                    if (!last_slice) begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
